// File: rtl/queue_fetch_unit_if.sv
// Signal bundle between the prefetch queue / execution sequencer (master) and queue_fetch_unit (slave).
interface queue_fetch_unit_if;
  logic [7:0]  prefetchTop;
  logic        prefetchEmpty;
  logic        advanceTop;
  logic        fetchReq;
  logic        fetchWord;
  logic        fetchSext;
  logic        fetchOpcode;
  logic        abort;
  logic        fetchAck;
  logic [15:0] fetchData;
  logic [2:0]  segOverride;
  logic        segOverrideValid;
  logic        busy;

  modport slave (
    input  prefetchTop, prefetchEmpty, fetchReq, fetchWord, fetchSext, fetchOpcode, abort,
    output advanceTop, fetchAck, fetchData, segOverride, segOverrideValid, busy
  );

  modport master (
    output prefetchTop, prefetchEmpty, fetchReq, fetchWord, fetchSext, fetchOpcode, abort,
    input  advanceTop, fetchAck, fetchData, segOverride, segOverrideValid, busy
  );
endinterface

// File: rtl/queue_fetch_unit.sv
// Prefetch-queue consumer: pops 1-2 bytes per request and returns a little-endian word with a 1-cycle ack.
// Segment-override prefix absorption on opcode fetches is built in when QFU_PREFIX_ABSORB_EN is defined.
module queue_fetch_unit (
  input logic               CLKx4,
  input logic               RESET,
  queue_fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ADV} state_t;

  state_t      state_q, state_d;
  logic        adv_q, adv_d;
  logic        ack_q, ack_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic        word_q, word_d;
  logic        sext_q, sext_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  seg_q, seg_d;
  logic        segv_q, segv_d;
  logic        is_prefix;
  logic [2:0]  prefix_seg;

`ifdef QFU_PREFIX_ABSORB_EN
  logic opc_q, opc_d;

  always_comb begin
    is_prefix  = opc_q;
    prefix_seg = 3'b000;
    case (bus.prefetchTop)
      8'h26:   prefix_seg = 3'b000;
      8'h2E:   prefix_seg = 3'b001;
      8'h36:   prefix_seg = 3'b010;
      8'h3E:   prefix_seg = 3'b011;
      default: is_prefix  = 1'b0;
    endcase
  end
`else
  assign is_prefix  = 1'b0;
  assign prefix_seg = 3'b000;
`endif

  always_comb begin
    state_d = state_q;
    adv_d   = adv_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    word_d  = word_q;
    sext_d  = sext_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    segv_d  = segv_q;
`ifdef QFU_PREFIX_ABSORB_EN
    opc_d   = opc_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      adv_d   = 1'b0;
      segv_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // ack_q blocks re-accepting the request the sequencer is still dropping
          if (bus.fetchReq && !ack_q) begin
            word_d  = bus.fetchWord;
            sext_d  = bus.fetchSext;
            cnt_d   = 2'd0;
            state_d = WAIT;
            if (bus.fetchOpcode) segv_d = 1'b0;
`ifdef QFU_PREFIX_ABSORB_EN
            opc_d   = bus.fetchOpcode;
`endif
          end
        end
        WAIT: begin
          adv_d = 1'b0;
          if (!bus.prefetchEmpty) begin
            adv_d   = 1'b1;
            state_d = ADV;
            if (is_prefix) begin
              seg_d  = prefix_seg;
              segv_d = 1'b1;
            end else begin
              if (cnt_q == 2'd0) b0_d = bus.prefetchTop;
              else               b1_d = bus.prefetchTop;
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        ADV: begin
          // Forced low cycle lets the queue settle its pointer before the next capture
          adv_d = 1'b0;
          if (cnt_q == {word_q, ~word_q}) begin
            ack_d   = 1'b1;
            data_d  = word_q ? {b1_q, b0_q} : {{8{sext_q & b0_q[7]}}, b0_q};
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKx4 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      adv_q   <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= 16'h0000;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      word_q  <= 1'b0;
      sext_q  <= 1'b0;
      cnt_q   <= 2'd0;
      seg_q   <= 3'b000;
      segv_q  <= 1'b0;
`ifdef QFU_PREFIX_ABSORB_EN
      opc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      word_q  <= word_d;
      sext_q  <= sext_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      segv_q  <= segv_d;
`ifdef QFU_PREFIX_ABSORB_EN
      opc_q   <= opc_d;
`endif
    end
  end

  assign bus.advanceTop       = adv_q;
  assign bus.fetchAck         = ack_q;
  assign bus.fetchData        = data_q;
  assign bus.segOverride      = seg_q;
  assign bus.segOverrideValid = segv_q;
  assign bus.busy             = (state_q != IDLE);
endmodule

// File: tb/tb_queue_fetch_unit.sv
// Bench for queue_fetch_unit: byte-queue model feeding the DUT, expected words held in a scoreboard queue.
`timescale 1ns/1ps
module tb_queue_fetch_unit;
  logic CLKx4 = 1'b0;
  logic RESET;
  queue_fetch_unit_if bus();

  queue_fetch_unit dut (.CLKx4(CLKx4), .RESET(RESET), .bus(bus.slave));

  always #5 CLKx4 = ~CLKx4;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_data = 16'h0000;
  bit          hold_empty = 1'b0;
  bit          adv_prev = 1'b0;
  int          pop_cnt = 0;
  int          cyc = 0;
  int          last_rise = -100;
  int          rise_gap = 0;

  // Prefetch queue model: pops on a rising advanceTop, presents head byte and empty flag
  always @(negedge CLKx4) begin
    cyc++;
    if (bus.advanceTop && !adv_prev) begin
      if (q.size() > 0) void'(q.pop_front());
      pop_cnt++;
      rise_gap  = cyc - last_rise;
      last_rise = cyc;
    end
    adv_prev          = bus.advanceTop;
    bus.prefetchTop   = (q.size() > 0) ? q[0] : 8'h00;
    bus.prefetchEmpty = (q.size() == 0) || hold_empty;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLKx4); #1;
    end
  endtask

  // Raises a request, counts edges from the accept edge (edge 1) until the ack pulse
  task automatic do_req(input logic w, input logic s, input logic o,
                        output int edges, output bit got, output logic [15:0] d);
    edges = 0; got = 1'b0; d = 16'h0000;
    bus.fetchWord = w; bus.fetchSext = s; bus.fetchOpcode = o; bus.fetchReq = 1'b1;
    while (!got && edges < 60) begin
      @(posedge CLKx4); #1;
      edges++;
      if (bus.fetchAck) begin
        got = 1'b1;
        d = bus.fetchData;
      end
    end
    bus.fetchReq = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.advanceTop !== 1'b0) begin errors++; $display("FAIL reset_adv: got %b want 0", bus.advanceTop); end
    checks++; if (bus.fetchAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.fetchAck); end
    checks++; if (bus.fetchData !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.fetchData); end
    checks++; if (bus.segOverride !== 3'b000) begin errors++; $display("FAIL reset_seg: got %b want 000", bus.segOverride); end
    checks++; if (bus.segOverrideValid !== 1'b0) begin errors++; $display("FAIL reset_segv: got %b want 0", bus.segOverrideValid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_byte_fetch;
    int e; bit g; logic [15:0] d, exp; int p0;
    q.push_back(8'hB8); idle(1);
    p0 = pop_cnt;
    exp_q.push_back(16'h00B8);
    do_req(1'b0, 1'b0, 1'b0, e, g, d);
    checks++; if (!g) begin errors++; $display("FAIL byte_ack: no ack within budget"); end
    checks++; if (e !== 3) begin errors++; $display("FAIL byte_latency: got %0d edges want 3", e); end
    exp = exp_q.pop_front(); last_data = exp;
    checks++; if (d !== exp) begin errors++; $display("FAIL byte_data: got %h want %h", d, exp); end
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL byte_pops: got %0d want 1", pop_cnt - p0); end
    idle(1);
    checks++; if (bus.fetchAck !== 1'b0) begin errors++; $display("FAIL byte_ack_pulse: ack still %b", bus.fetchAck); end
  endtask

  task automatic test_word_fetch;
    int e; bit g; logic [15:0] d, exp; int p0;
    q.push_back(8'h34); q.push_back(8'h12); idle(1);
    p0 = pop_cnt;
    exp_q.push_back(16'h1234);
    do_req(1'b1, 1'b0, 1'b0, e, g, d);
    checks++; if (!g) begin errors++; $display("FAIL word_ack: no ack within budget"); end
    checks++; if (e !== 5) begin errors++; $display("FAIL word_latency: got %0d edges want 5", e); end
    exp = exp_q.pop_front(); last_data = exp;
    checks++; if (d !== exp) begin errors++; $display("FAIL word_data: got %h want %h", d, exp); end
    checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL word_pops: got %0d want 2", pop_cnt - p0); end
    checks++; if (rise_gap !== 2) begin errors++; $display("FAIL word_pop_gap: got %0d cycles want 2", rise_gap); end
    idle(1);
    checks++; if (bus.fetchAck !== 1'b0) begin errors++; $display("FAIL word_ack_pulse: ack still %b", bus.fetchAck); end
  endtask

  task automatic test_sext;
    int e; bit g; logic [15:0] d, exp;
    logic [7:0]  bytes [3] = '{8'hF0, 8'hF0, 8'h70};
    logic        sx    [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      q.push_back(bytes[i]); idle(1);
      exp_q.push_back({(sx[i] && bytes[i][7]) ? 8'hFF : 8'h00, bytes[i]});
      do_req(1'b0, sx[i], 1'b0, e, g, d);
      exp = exp_q.pop_front(); last_data = exp;
      checks++; if (!g || d !== exp) begin errors++; $display("FAIL sext_%0d: ack=%0d data %h want %h", i, g, d, exp); end
      idle(1);
    end
  endtask

  task automatic test_stall;
    int e; bit got; bit stall_ok; int p0; logic [15:0] exp;
    hold_empty = 1'b1; q.push_back(8'h7E); idle(1);
    p0 = pop_cnt; stall_ok = 1'b1;
    exp_q.push_back(16'h007E);
    bus.fetchWord = 1'b0; bus.fetchSext = 1'b0; bus.fetchOpcode = 1'b0; bus.fetchReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLKx4); #1;
      if (bus.advanceTop !== 1'b0 || bus.fetchAck !== 1'b0 || bus.busy !== 1'b1) stall_ok = 1'b0;
    end
    checks++; if (!stall_ok) begin errors++; $display("FAIL stall_quiet: advanceTop/ack/busy wrong while empty"); end
    hold_empty = 1'b0;
    e = 0; got = 1'b0;
    while (!got && e < 20) begin
      @(posedge CLKx4); #1; e++;
      if (bus.fetchAck) got = 1'b1;
    end
    bus.fetchReq = 1'b0;
    checks++; if (!got || e !== 2) begin errors++; $display("FAIL stall_latency: ack=%0d after %0d edges want 2", got, e); end
    exp = exp_q.pop_front(); last_data = exp;
    checks++; if (bus.fetchData !== exp) begin errors++; $display("FAIL stall_data: got %h want %h", bus.fetchData, exp); end
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL stall_pops: got %0d want 1", pop_cnt - p0); end
    idle(1);
  endtask

  task automatic test_prefix;
    int e; bit g; logic [15:0] d, exp; int p0;
    q.push_back(8'h2E); q.push_back(8'h26); q.push_back(8'h90); idle(1);
    p0 = pop_cnt;
`ifdef QFU_PREFIX_ABSORB_EN
    exp_q.push_back(16'h0090);
    do_req(1'b0, 1'b0, 1'b1, e, g, d);
    checks++; if (!g || e !== 7) begin errors++; $display("FAIL prefix_latency: ack=%0d edges %0d want 7", g, e); end
    checks++; if (pop_cnt - p0 !== 3) begin errors++; $display("FAIL prefix_pops: got %0d want 3", pop_cnt - p0); end
    checks++; if (bus.segOverride !== 3'b000 || bus.segOverrideValid !== 1'b1) begin
      errors++; $display("FAIL prefix_seg: seg %b valid %b want 000/1", bus.segOverride, bus.segOverrideValid); end
`else
    exp_q.push_back(16'h002E);
    do_req(1'b0, 1'b0, 1'b1, e, g, d);
    checks++; if (!g || e !== 3) begin errors++; $display("FAIL prefix_latency: ack=%0d edges %0d want 3", g, e); end
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL prefix_pops: got %0d want 1", pop_cnt - p0); end
    checks++; if (bus.segOverride !== 3'b000 || bus.segOverrideValid !== 1'b0) begin
      errors++; $display("FAIL prefix_seg: seg %b valid %b want 000/0", bus.segOverride, bus.segOverrideValid); end
`endif
    exp = exp_q.pop_front(); last_data = exp;
    checks++; if (d !== exp) begin errors++; $display("FAIL prefix_data: got %h want %h", d, exp); end
    q.delete(); idle(2);
    // A fresh opcode fetch drops any override left from the previous instruction
    q.push_back(8'h90); idle(1);
    exp_q.push_back(16'h0090);
    do_req(1'b0, 1'b0, 1'b1, e, g, d);
    exp = exp_q.pop_front(); last_data = exp;
    checks++; if (!g || d !== exp || bus.segOverrideValid !== 1'b0) begin
      errors++; $display("FAIL prefix_clear: ack=%0d data %h valid %b want %h/0", g, d, bus.segOverrideValid, exp); end
    idle(1);
  endtask

  task automatic test_abort;
    int p0;
    q.push_back(8'h34); q.push_back(8'h12); idle(1);
    p0 = pop_cnt;
    bus.fetchWord = 1'b1; bus.fetchSext = 1'b0; bus.fetchOpcode = 1'b0; bus.fetchReq = 1'b1;
    idle(2);
    checks++; if (bus.advanceTop !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_setup: adv %b busy %b want 1/1", bus.advanceTop, bus.busy); end
    bus.abort = 1'b1;
    idle(1);
    bus.abort = 1'b0; bus.fetchReq = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.fetchAck !== 1'b0 || bus.advanceTop !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy %b ack %b adv %b want 0/0/0", bus.busy, bus.fetchAck, bus.advanceTop); end
    checks++; if (bus.fetchData !== last_data) begin errors++; $display("FAIL abort_data: got %h want %h", bus.fetchData, last_data); end
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL abort_pops: got %0d want 1", pop_cnt - p0); end
    q.delete(); idle(2);
    bus.abort = 1'b1; bus.fetchReq = 1'b1; bus.fetchWord = 1'b0;
    idle(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_wins: busy %b want 0", bus.busy); end
    bus.abort = 1'b0; bus.fetchReq = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_in_adv;
    q.push_back(8'hAB); idle(1);
    bus.fetchWord = 1'b0; bus.fetchSext = 1'b0; bus.fetchOpcode = 1'b0; bus.fetchReq = 1'b1;
    idle(2);
    checks++; if (bus.advanceTop !== 1'b1) begin errors++; $display("FAIL rst_adv_setup: adv %b want 1", bus.advanceTop); end
    RESET = 1'b1; bus.fetchReq = 1'b0;
    #1;
    test_reset();
    @(negedge CLKx4); RESET = 1'b0;
    q.delete(); idle(2);
  endtask

  initial begin
    bus.fetchReq = 1'b0; bus.fetchWord = 1'b0; bus.fetchSext = 1'b0;
    bus.fetchOpcode = 1'b0; bus.abort = 1'b0;
    RESET = 1'b1;
    idle(2);
    test_reset();
    @(negedge CLKx4); RESET = 1'b0;
    idle(1);
    test_byte_fetch();
    test_word_fetch();
    test_sext();
    test_stall();
    test_prefix();
    test_abort();
    test_reset_in_adv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
